// File: rtl/tlc_request_scheduler_if.sv
// Signal bundle between pedestrian buttons, emergency sources, the scheduler and the TLC.
interface tlc_request_scheduler_if #(
  parameter int N_PED = 4,
  parameter int N_EMG = 2
);
  localparam int PW = (N_PED > 1) ? $clog2(N_PED) : 1;
  localparam int EW = (N_EMG > 1) ? $clog2(N_EMG) : 1;

  logic [N_PED-1:0] ped_btn;
  logic [N_EMG-1:0] emg_req;
  logic             ped_ack;
  logic             ped_done;
  logic             ped_call;
  logic [PW-1:0]    ped_id;
  logic             emergency;
  logic [EW-1:0]    emg_id;
  logic [N_PED-1:0] ped_pending;
  logic             emg_timeout;

  modport master (
    output ped_btn, emg_req, ped_ack, ped_done,
    input  ped_call, ped_id, emergency, emg_id, ped_pending, emg_timeout
  );

  modport slave (
    input  ped_btn, emg_req, ped_ack, ped_done,
    output ped_call, ped_id, emergency, emg_id, ped_pending, emg_timeout
  );
endinterface

// File: rtl/tlc_request_scheduler.sv
// Arbitrates pedestrian calls (round-robin with recovery gap) and emergency requests
// (fixed priority with hold watchdog) into single service requests for the TLC.
module tlc_request_scheduler #(
  parameter int N_PED   = 4,
  parameter int N_EMG   = 2,
  parameter int PED_GAP = 8,
  parameter int EMG_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  tlc_request_scheduler_if.slave  bus_if
);
  localparam int PW = (N_PED > 1) ? $clog2(N_PED) : 1;
  localparam int EW = (N_EMG > 1) ? $clog2(N_EMG) : 1;
  localparam int GW = (PED_GAP > 1) ? $clog2(PED_GAP) : 1;
  localparam int HW = $clog2(EMG_MAX);
  localparam logic [GW-1:0] GAP_LAST  = GW'(PED_GAP - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(EMG_MAX - 1);
  localparam logic [PW-1:0] PTR_INIT  = PW'(N_PED - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PED_REQ,
    S_PED_WAIT,
    S_GAP,
    S_EMG,
    S_EMG_CLR
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_EMG-1:0] mask_q, mask_d;
  logic [N_PED-1:0] pending_q, pending_d;
  logic             ped_call_q, ped_call_d;
  logic [PW-1:0]    ped_id_q, ped_id_d;
  logic             emergency_q, emergency_d;
  logic [EW-1:0]    emg_id_q, emg_id_d;
  logic             timeout_q, timeout_d;

  logic [N_EMG-1:0] eligible;
  logic [N_EMG-1:0] mask_set;
  logic             emg_any;
  logic [EW-1:0]    emg_win;
  logic [N_PED-1:0] above_ptr;
  logic [N_PED-1:0] cand_hi;
  logic [N_PED-1:0] ped_src;
  logic [PW-1:0]    ped_win;
  logic [N_PED-1:0] ped_clr;
  logic             pend_clr_en;

  assign eligible = bus_if.emg_req & ~mask_q;
  assign emg_any  = |eligible;

  always_comb begin
    emg_win = '0;
    for (int k = N_EMG - 1; k >= 0; k--) begin
      if (eligible[k]) emg_win = EW'(k);
    end
  end

  // Round-robin: prefer pending indices above the pointer, otherwise wrap to the lowest.
  for (genvar gi = 0; gi < N_PED; gi++) begin : g_rr
    assign above_ptr[gi] = (PW'(gi) > ptr_q);
    assign ped_clr[gi]   = pend_clr_en && (ped_id_q == PW'(gi));
  end

  assign cand_hi = pending_q & above_ptr;
  assign ped_src = (|cand_hi) ? cand_hi : pending_q;

  always_comb begin
    ped_win = '0;
    for (int k = N_PED - 1; k >= 0; k--) begin
      if (ped_src[k]) ped_win = PW'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_cnt_d   = gap_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    ped_call_d  = ped_call_q;
    ped_id_d    = ped_id_q;
    emergency_d = emergency_q;
    emg_id_d    = emg_id_q;
    timeout_d   = timeout_q;
    mask_set    = '0;
    pend_clr_en = 1'b0;

    if (emg_any && (state_q != S_EMG) && (state_q != S_EMG_CLR)) begin
      state_d     = S_EMG;
      emergency_d = 1'b1;
      emg_id_d    = emg_win;
      hold_cnt_d  = '0;
      ped_call_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            state_d    = S_PED_REQ;
            ped_call_d = 1'b1;
            ped_id_d   = ped_win;
            ptr_d      = ped_win;
          end
        end
        S_PED_REQ: begin
          if (bus_if.ped_ack) begin
            state_d     = S_PED_WAIT;
            ped_call_d  = 1'b0;
            pend_clr_en = 1'b1;
          end
        end
        S_PED_WAIT: begin
          if (bus_if.ped_done) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        S_EMG: begin
          if (!bus_if.emg_req[emg_id_q]) begin
            state_d     = S_EMG_CLR;
            emergency_d = 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d            = S_EMG_CLR;
            emergency_d        = 1'b0;
            mask_set[emg_id_q] = 1'b1;
            timeout_d          = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        S_EMG_CLR: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // A new press in the same cycle as the clear keeps the call latched.
  assign pending_d = (pending_q & ~ped_clr) | bus_if.ped_btn;
  assign mask_d    = (mask_q & bus_if.emg_req) | mask_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_INIT;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      ped_call_q  <= 1'b0;
      ped_id_q    <= '0;
      emergency_q <= 1'b0;
      emg_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      ped_call_q  <= ped_call_d;
      ped_id_q    <= ped_id_d;
      emergency_q <= emergency_d;
      emg_id_q    <= emg_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus_if.ped_call    = ped_call_q;
  assign bus_if.ped_id      = ped_id_q;
  assign bus_if.emergency   = emergency_q;
  assign bus_if.emg_id      = emg_id_q;
  assign bus_if.ped_pending = pending_q;
  assign bus_if.emg_timeout = timeout_q;
endmodule

// File: tb/tb_tlc_request_scheduler.sv
// Self-checking bench for tlc_request_scheduler: directed scenarios plus random traffic
// compared against a behavioural model of the scheduling rules.
module tb_tlc_request_scheduler;
  localparam int N_PED   = 4;
  localparam int N_EMG   = 2;
  localparam int PED_GAP = 8;
  localparam int EMG_MAX = 16;
  localparam int PW      = 2;
  localparam int EW      = 1;

  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_GAP = 3, P_EMG = 4, P_CLR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tlc_request_scheduler_if #(.N_PED(N_PED), .N_EMG(N_EMG)) sif ();

  tlc_request_scheduler #(
    .N_PED(N_PED), .N_EMG(N_EMG), .PED_GAP(PED_GAP), .EMG_MAX(EMG_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (sif)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks phase, remaining gap/hold budgets and the expected outputs.
  int               m_phase, m_ptr, m_gap_left, m_emg_left, m_win;
  logic [N_PED-1:0] m_pend, m_pend_n;
  logic [N_EMG-1:0] m_mask, m_mask_n;
  logic             exp_call, exp_emg, exp_to;
  int               exp_pid, exp_eid;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_ptr = N_PED - 1; m_gap_left = 0; m_emg_left = 0;
      m_pend = '0; m_mask = '0;
      exp_call = 1'b0; exp_emg = 1'b0; exp_to = 1'b0; exp_pid = 0; exp_eid = 0;
    end else begin
      m_pend_n = m_pend | sif.ped_btn;
      m_mask_n = m_mask & sif.emg_req;
      m_win = -1;
      for (int k = N_EMG - 1; k >= 0; k--) if (sif.emg_req[k] && !m_mask[k]) m_win = k;
      if (m_win >= 0 && m_phase != P_EMG && m_phase != P_CLR) begin
        m_phase = P_EMG; exp_emg = 1'b1; exp_eid = m_win; m_emg_left = EMG_MAX; exp_call = 1'b0;
      end else begin
        case (m_phase)
          P_IDLE: begin
            m_win = -1;
            for (int k = N_PED; k >= 1; k--) if (m_pend[(m_ptr + k) % N_PED]) m_win = (m_ptr + k) % N_PED;
            if (m_win >= 0) begin
              m_phase = P_REQ; exp_call = 1'b1; exp_pid = m_win; m_ptr = m_win;
            end
          end
          P_REQ: if (sif.ped_ack) begin
            m_phase = P_WAIT; exp_call = 1'b0; m_pend_n[exp_pid] = sif.ped_btn[exp_pid];
          end
          P_WAIT: if (sif.ped_done) begin
            m_phase = P_GAP; m_gap_left = PED_GAP;
          end
          P_GAP: begin
            m_gap_left--;
            if (m_gap_left == 0) m_phase = P_IDLE;
          end
          P_EMG: begin
            m_emg_left--;
            if (!sif.emg_req[exp_eid]) begin
              m_phase = P_CLR; exp_emg = 1'b0;
            end else if (m_emg_left == 0) begin
              m_phase = P_CLR; exp_emg = 1'b0; m_mask_n[exp_eid] = 1'b1; exp_to = 1'b1;
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
      m_pend = m_pend_n;
      m_mask = m_mask_n;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    sif.ped_btn = '0; sif.emg_req = '0; sif.ped_ack = 1'b0; sif.ped_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_inputs(); step(); rst = 1'b0;
  endtask

  task automatic drain_walk();
    sif.ped_done = 1'b1; step(); sif.ped_done = 1'b0;
    repeat (PED_GAP) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs(); step();
    checks += 6;
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL reset_call: got %0b expected 0", sif.ped_call); end
    if (sif.ped_id !== 2'd0) begin errors++; $display("FAIL reset_pid: got %0d expected 0", sif.ped_id); end
    if (sif.emergency !== 1'b0) begin errors++; $display("FAIL reset_emg: got %0b expected 0", sif.emergency); end
    if (sif.emg_id !== 1'b0) begin errors++; $display("FAIL reset_eid: got %0d expected 0", sif.emg_id); end
    if (sif.ped_pending !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b expected 0000", sif.ped_pending); end
    if (sif.emg_timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %0b expected 0", sif.emg_timeout); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_ped();
    do_reset();
    sif.ped_btn = 4'b0100; step(); sif.ped_btn = '0;
    checks += 2;
    if (sif.ped_pending !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b expected 0100", sif.ped_pending); end
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL single_early_call: got %0b expected 0", sif.ped_call); end
    step();
    checks += 2;
    if (sif.ped_call !== 1'b1) begin errors++; $display("FAIL single_call: got %0b expected 1", sif.ped_call); end
    if (sif.ped_id !== 2'd2) begin errors++; $display("FAIL single_pid: got %0d expected 2", sif.ped_id); end
    sif.ped_ack = 1'b1; step(); sif.ped_ack = 1'b0;
    checks += 2;
    if (sif.ped_pending !== 4'b0000) begin errors++; $display("FAIL single_clr: got %b expected 0000", sif.ped_pending); end
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL single_call_drop: got %0b expected 0", sif.ped_call); end
    drain_walk();
    $display("test_single_ped done");
  endtask

  task automatic test_round_robin();
    int order[3] = '{0, 1, 3};
    int gap_calls;
    do_reset();
    sif.ped_btn = 4'b1011; step(); sif.ped_btn = '0; step();
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (sif.ped_call !== 1'b1) begin errors++; $display("FAIL rr_call%0d: got %0b expected 1", i, sif.ped_call); end
      if (sif.ped_id !== order[i][PW-1:0]) begin errors++; $display("FAIL rr_pid%0d: got %0d expected %0d", i, sif.ped_id, order[i]); end
      sif.ped_ack = 1'b1; step(); sif.ped_ack = 1'b0;
      sif.ped_done = 1'b1; step(); sif.ped_done = 1'b0;
      gap_calls = 0;
      for (int c = 0; c < PED_GAP; c++) begin
        if (sif.ped_call !== 1'b0) gap_calls++;
        step();
      end
      checks++;
      if (gap_calls != 0 || sif.ped_call !== 1'b0) begin
        errors++; $display("FAIL rr_gap%0d: got %0d calls during gap expected 0", i, gap_calls);
      end
      step();
      checks++;
      if (sif.ped_call !== (i < 2 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL rr_after_gap%0d: got %0b expected %0b", i, sif.ped_call, (i < 2));
      end
      $display("rr grant %0d id=%0d", i, order[i]);
    end
  endtask

  task automatic test_emg_preempt();
    do_reset();
    sif.ped_btn = 4'b0010; step(); sif.ped_btn = '0; step();
    checks += 2;
    if (sif.ped_call !== 1'b1) begin errors++; $display("FAIL pre_call: got %0b expected 1", sif.ped_call); end
    if (sif.ped_id !== 2'd1) begin errors++; $display("FAIL pre_pid: got %0d expected 1", sif.ped_id); end
    sif.emg_req = 2'b11; step();
    checks += 4;
    if (sif.emergency !== 1'b1) begin errors++; $display("FAIL pre_emg: got %0b expected 1", sif.emergency); end
    if (sif.emg_id !== 1'b0) begin errors++; $display("FAIL pre_eid: got %0d expected 0", sif.emg_id); end
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL pre_call_drop: got %0b expected 0", sif.ped_call); end
    if (sif.ped_pending[1] !== 1'b1) begin errors++; $display("FAIL pre_pend_kept: got %b expected x x 1 x", sif.ped_pending); end
    sif.emg_req = 2'b10; step();
    checks++;
    if (sif.emergency !== 1'b0) begin errors++; $display("FAIL pre_clr: got %0b expected 0", sif.emergency); end
    step();
    checks++;
    if (sif.emergency !== 1'b0) begin errors++; $display("FAIL pre_idle: got %0b expected 0", sif.emergency); end
    step();
    checks += 2;
    if (sif.emergency !== 1'b1) begin errors++; $display("FAIL pre_regrant: got %0b expected 1", sif.emergency); end
    if (sif.emg_id !== 1'b1) begin errors++; $display("FAIL pre_regrant_eid: got %0d expected 1", sif.emg_id); end
    sif.emg_req = 2'b00; step(); step(); step();
    checks += 2;
    if (sif.ped_call !== 1'b1) begin errors++; $display("FAIL pre_resume_call: got %0b expected 1", sif.ped_call); end
    if (sif.ped_id !== 2'd1) begin errors++; $display("FAIL pre_resume_pid: got %0d expected 1", sif.ped_id); end
    sif.ped_ack = 1'b1; step(); sif.ped_ack = 1'b0;
    drain_walk();
    $display("test_emg_preempt done");
  endtask

  task automatic test_emg_watchdog();
    int high_cnt;
    int first_low;
    do_reset();
    sif.emg_req = 2'b01;
    high_cnt = 0; first_low = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (sif.emergency === 1'b1) high_cnt++;
      else if (first_low < 0) first_low = c;
    end
    checks += 3;
    if (high_cnt != EMG_MAX) begin errors++; $display("FAIL wd_hold: got %0d cycles expected %0d", high_cnt, EMG_MAX); end
    if (first_low != EMG_MAX + 1) begin errors++; $display("FAIL wd_release: got cycle %0d expected %0d", first_low, EMG_MAX + 1); end
    if (sif.emg_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %0b expected 1", sif.emg_timeout); end
    sif.emg_req = 2'b00; step();
    sif.emg_req = 2'b01; step();
    checks += 2;
    if (sif.emergency !== 1'b1) begin errors++; $display("FAIL wd_rearm: got %0b expected 1", sif.emergency); end
    if (sif.emg_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b expected 1", sif.emg_timeout); end
    sif.emg_req = 2'b00; step(); step();
    $display("test_emg_watchdog done");
  endtask

  task automatic test_set_clear_same();
    do_reset();
    sif.ped_btn = 4'b0100; step(); sif.ped_btn = '0; step();
    sif.ped_ack = 1'b1; sif.ped_btn = 4'b0100; step(); sif.ped_ack = 1'b0; sif.ped_btn = '0;
    checks += 2;
    if (sif.ped_pending[2] !== 1'b1) begin errors++; $display("FAIL sc_pend: got %b expected x 1 x x", sif.ped_pending); end
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL sc_call: got %0b expected 0", sif.ped_call); end
    drain_walk(); step();
    checks += 2;
    if (sif.ped_call !== 1'b1) begin errors++; $display("FAIL sc_reserve: got %0b expected 1", sif.ped_call); end
    if (sif.ped_id !== 2'd2) begin errors++; $display("FAIL sc_reserve_pid: got %0d expected 2", sif.ped_id); end
    sif.ped_ack = 1'b1; step(); sif.ped_ack = 1'b0;
    drain_walk();
    $display("test_set_clear_same done");
  endtask

  task automatic test_reset_midop();
    do_reset();
    sif.ped_btn = 4'b0010; step(); sif.ped_btn = '0; step();
    sif.ped_ack = 1'b1; step(); sif.ped_ack = 1'b0;
    sif.ped_btn = 4'b1000; step(); sif.ped_btn = '0;
    rst = 1'b1; step(); rst = 1'b0;
    checks += 3;
    if (sif.ped_pending !== 4'b0000) begin errors++; $display("FAIL rw_pend: got %b expected 0000", sif.ped_pending); end
    if (sif.ped_call !== 1'b0) begin errors++; $display("FAIL rw_call: got %0b expected 0", sif.ped_call); end
    if (sif.ped_id !== 2'd0) begin errors++; $display("FAIL rw_pid: got %0d expected 0", sif.ped_id); end
    sif.ped_btn = 4'b0101; step(); sif.ped_btn = '0; step();
    checks++;
    if (sif.ped_id !== 2'd0) begin errors++; $display("FAIL rw_ptr: got %0d expected 0", sif.ped_id); end
    sif.emg_req = 2'b10; step();
    checks++;
    if (sif.emergency !== 1'b1) begin errors++; $display("FAIL re_emg: got %0b expected 1", sif.emergency); end
    rst = 1'b1; sif.emg_req = 2'b00; step(); rst = 1'b0;
    checks += 4;
    if (sif.emergency !== 1'b0) begin errors++; $display("FAIL re_emg_rst: got %0b expected 0", sif.emergency); end
    if (sif.emg_id !== 1'b0) begin errors++; $display("FAIL re_eid_rst: got %0d expected 0", sif.emg_id); end
    if (sif.ped_pending !== 4'b0000) begin errors++; $display("FAIL re_pend_rst: got %b expected 0000", sif.ped_pending); end
    if (sif.emg_timeout !== 1'b0) begin errors++; $display("FAIL re_to_rst: got %0b expected 0", sif.emg_timeout); end
    sif.ped_btn = 4'b1001; step(); sif.ped_btn = '0; step();
    checks++;
    if (sif.ped_id !== 2'd0) begin errors++; $display("FAIL re_ptr: got %0d expected 0", sif.ped_id); end
    $display("test_reset_midop done");
  endtask

  task automatic test_random();
    int bit_sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      sif.ped_btn  = ($urandom_range(0, 9) == 0) ? N_PED'($urandom) : '0;
      sif.ped_ack  = ($urandom_range(0, 3) == 0);
      sif.ped_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 23) == 0) begin
        bit_sel = $urandom_range(0, N_EMG - 1);
        sif.emg_req[bit_sel] = ~sif.emg_req[bit_sel];
      end
      step();
      checks += 4;
      if (sif.ped_call !== exp_call) begin errors++; $display("FAIL rnd_call c=%0d: got %0b expected %0b", c, sif.ped_call, exp_call); end
      if (sif.ped_pending !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d: got %b expected %b", c, sif.ped_pending, m_pend); end
      if (sif.emergency !== exp_emg) begin errors++; $display("FAIL rnd_emg c=%0d: got %0b expected %0b", c, sif.emergency, exp_emg); end
      if (sif.emg_timeout !== exp_to) begin errors++; $display("FAIL rnd_to c=%0d: got %0b expected %0b", c, sif.emg_timeout, exp_to); end
      if (exp_call || m_phase == P_WAIT) begin
        checks++;
        if (sif.ped_id !== exp_pid[PW-1:0]) begin errors++; $display("FAIL rnd_pid c=%0d: got %0d expected %0d", c, sif.ped_id, exp_pid); end
      end
      if (exp_emg) begin
        checks++;
        if (sif.emg_id !== exp_eid[EW-1:0]) begin errors++; $display("FAIL rnd_eid c=%0d: got %0d expected %0d", c, sif.emg_id, exp_eid); end
      end
    end
    rst = 1'b0; clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_ped();
    test_round_robin();
    test_emg_preempt();
    test_emg_watchdog();
    test_set_clear_same();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_limit: got no completion expected finish within bound");
    $fatal(1, "time limit");
  end
endmodule
